// File: rtl/xor_serial_arbiter.sv
// rtl/xor_serial_arbiter.sv - round-robin arbiter sharing one gate_xor for bit-serial word XOR

module gate_xor (
  input  logic inp1,
  input  logic inp2,
  output logic y
);
  xor g0 (y, inp1, inp2);
endmodule

module xor_serial_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] op_a,
  input  logic [4*WIDTH-1:0] op_b,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_id,
  output logic [WIDTH-1:0]   result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rr_ptr, id, win, base, idx;
  logic             found, accept, last_bit, xor_bit;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;

  gate_xor u_xor (
    .inp1 (a_sh[0]),
    .inp2 (b_sh[0]),
    .y    (xor_bit)
  );

  // DONE hands priority straight to id+1 and may accept, keeping the
  // operation period at WIDTH+1 cycles.
  always_comb begin
    base  = (state == DONE) ? id + 2'd1 : rr_ptr;
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept   = found && (state == IDLE || state == DONE);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= 2'd0;
      id      <= 2'd0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      gnt     <= 4'd0;
      done    <= 1'b0;
      done_id <= 2'd0;
      result  <= '0;
    end else begin
      gnt  <= 4'd0;
      done <= 1'b0;
      case (state)
        SHIFT: begin
          result <= {xor_bit, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            done    <= 1'b1;
            done_id <= id;
          end
        end
        default: begin
          if (state == DONE) rr_ptr <= id + 2'd1;
          if (accept) begin
            a_sh <= op_a[int'(win)*WIDTH +: WIDTH];
            b_sh <= op_b[int'(win)*WIDTH +: WIDTH];
            id   <= win;
            cnt  <= '0;
            gnt  <= 4'b0001 << win;
          end
        end
      endcase
    end
  end
endmodule
